csr_counter_unit: RTL and testbench
===================================

# csr_counter_unit

Parametrised Zicsr control/status register unit with 64-bit hardware performance counters. It decodes all six CSR instructions (CSRRW/RS/RC and immediate forms) against a fixed address map: mcycle, minstret, NUM_HPM event counters, mcountinhibit, mscratch, and their read-only user aliases. It sits beside the execute stage: it takes one request per cycle and returns the old CSR value plus an illegal flag one cycle later.

## Interface
- XLEN, 32: data width of CSR read/write path.
- CNT_WIDTH, 64: width of every counter; must equal 2*XLEN.
- NUM_HPM, 4: number of mhpmcounter3.. counters, 0..29.
- CSR_ADDR_W, 12: CSR address width.
- CSR_OP_WIDTH, 3: op field width, RISC-V funct3 encoding.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  CSR request this cycle.
- csr_addr_i  in  CSR_ADDR_W  target CSR.
- csr_op_i  in  CSR_OP_WIDTH  1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI; 0 and 4 illegal.
- csr_wdata_i  in  XLEN  rs1 value or zero-extended uimm.
- instret_i  in  1  one instruction retired this cycle.
- hpm_event_i  in  NUM_HPM  per-counter event pulses.
- rsp_valid_o  out  1  response valid.
- rsp_rdata_o  out  XLEN  old CSR value.
- rsp_illegal_o  out  1  request was illegal.

## Operation
- Address map: mcycle B00/B80(h); minstret B02/B82; mhpmcounter(3+k) B03+k/B83+k; mcountinhibit 320; mscratch 340. Read-only aliases: cycle C00/C80, time C01/C81 (both alias mcycle), instret C02/C82, hpmcounter(3+k) C03+k/C83+k.
- New value: RW/RWI give wdata. RS/RSI give old | wdata. RC/RCI give old & ~wdata.
- RS/RC/RSI/RCI with wdata==0 perform no write. RW/RWI always write.
- Illegal cases: unmapped address, op 0 or 4, or any write attempt to an address with addr[11:10]==2'b11.
- An illegal request changes no state, returns rdata 0, and asserts illegal.
- mcountinhibit:
  - bit0 inhibits mcycle; bit2 inhibits minstret; bit 3+k inhibits hpm k.
  - bit1 and all unimplemented bits are read-zero and ignore writes.
- Increments: mcycle +1 every cycle; minstret +1 when instret_i; hpm k +1 when hpm_event_i[k]. Each increment applies only when the counter is not inhibited.
- A write to the low half replaces bits [XLEN-1:0] and preserves the high half; a write to the high half is symmetric.
- A software write to a counter in the same cycle as its increment wins; that increment is dropped.
- Counters wrap from all-ones to 0 silently; the carry from the low half propagates into the high half in the same cycle.

## Timing
- Request accepted on any posedge with req_valid_i high; there is no backpressure.
- rsp_valid_o rises the next cycle for exactly one cycle.
- rsp_rdata_o is the CSR value held before that edge's update, i.e. before both the write and the increment.
- Back-to-back requests: one per cycle. A request reads state including all writes from earlier requests.
- Reset:
  - all counters, mscratch and mcountinhibit go to 0;
  - rsp_valid_o, rsp_rdata_o and rsp_illegal_o go to 0;
  - a request in the reset cycle is discarded and gets no response.
- After reset deasserts, mcycle reads 0 on the first cycle and then counts.
- No combinational path from any input to any output.

## Structure
- Shared defines header: CSR address localparams, op encodings, mcountinhibit bit indices, and the illegal-check macro for addr[11:10].
- Sub-module csr_counter64, instanced once per counter (cycle, instret, NUM_HPM):
  - inputs: inc_en, wr_lo, wr_hi, wdata;
  - output: value;
  - holds the write-over-increment priority and the carry logic.
- Top level holds: decode, op ALU, mscratch, mcountinhibit, response register.

## Test plan
- Reset, idle 10 cycles, read C00 (CSRRS, wdata 0) → rdata 10 or 11 per edge alignment, documented and checked exactly; illegal 0.
- CSRRW B00 with FFFF_FFFF, then read B80 twice → low half wraps; high half goes 0 → 1 on carry.
- CSRRWI 320 with uimm 5, pulse instret_i 3 cycles, read B02 → 0; read 320 → 5 (bit1 reads 0 if set).
- CSRRW C00 → illegal 1, rdata 0, mcycle unaffected. CSRRS C00 with wdata 0 → legal. op 4 → illegal.
- CSRRW 340=A5A5_A5A5, then same-cycle-following CSRRC 340 with 0000_00FF → rdata A5A5_A5A5; next read → A5A5_A500.
- CSRRW B03 with 7 in the same cycle as hpm_event_i[0] → counter reads 7, not 8. Assert rst mid-burst → responses drop to 0 and the pending response is suppressed.

Source files
------------

// File: rtl/csr_counter_unit_pkg.sv
// Shared definitions for the CSR counter unit: address map, op encodings,
// mcountinhibit bit layout and small decode helpers.
// No ports; imported by csr_counter_unit and csr_counter64.

// True when the address lies in the read-only CSR space (addr[11:10] == 2'b11).
`define CSR_ADDR_IS_RO(a) ((a[11:10]) == 2'b11)

package csr_counter_unit_pkg;

  // Machine counter bases. HPM counter k lives at base + 3 + k.
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  // User read-only aliases.
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_TIME          = 12'hC01;
  localparam logic [11:0] ADDR_TIMEH         = 12'hC81;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;

  // funct3 encodings of the six Zicsr instructions.
  localparam logic [2:0] OP_RW  = 3'd1;
  localparam logic [2:0] OP_RS  = 3'd2;
  localparam logic [2:0] OP_RC  = 3'd3;
  localparam logic [2:0] OP_RWI = 3'd5;
  localparam logic [2:0] OP_RSI = 3'd6;
  localparam logic [2:0] OP_RCI = 3'd7;

  // mcountinhibit bit positions.
  localparam int INH_CY   = 0;
  localparam int INH_IR   = 2;
  localparam int INH_HPM0 = 3;

  // Register and immediate forms collapse to the same operation class.
  typedef enum logic [1:0] {
    OPK_NONE = 2'd0,
    OPK_RW   = 2'd1,
    OPK_RS   = 2'd2,
    OPK_RC   = 2'd3
  } csr_opk_e;

  // Counter index: 0 = cycle, 1 = instret, 2+k = hpm k.
  // Offset of a counter from the B00/B80/C00/C80 bases.
  function automatic logic [11:0] cnt_offset(input int idx);
    return (idx == 0) ? 12'd0 : 12'(idx + 1);
  endfunction

  // mcountinhibit bit that gates counter idx.
  function automatic int inh_bit(input int idx);
    if (idx == 0) return INH_CY;
    if (idx == 1) return INH_IR;
    return INH_HPM0 + idx - 2;
  endfunction

  // Writable mcountinhibit bits; bit1 and unimplemented HPM bits stay zero.
  function automatic logic [31:0] inh_mask(input int num_hpm);
    logic [31:0] m;
    m = '0;
    m[INH_CY] = 1'b1;
    m[INH_IR] = 1'b1;
    for (int k = 0; k < num_hpm; k++) m[INH_HPM0 + k] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// One wide performance counter with half-word software write ports.
// Latency: writes and increments land on the next clk edge. No backpressure.
// Ports: clk, rst (sync, active-high), inc_en, wr_lo, wr_hi, wdata -> value.
module csr_counter64
  import csr_counter_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [XLEN-1:0]      wdata,
  output logic [CNT_WIDTH-1:0] value
);

  // A software write replaces one half and swallows this cycle's increment.
  // The full-width add carries from the low half into the high half.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[XLEN-1:0] <= wdata;
    end else if (wr_hi) begin
      value[CNT_WIDTH-1:XLEN] <= wdata;
    end else if (inc_en) begin
      value <= value + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/csr_counter_unit.sv
// Zicsr register unit: cycle/instret/HPM counters, mcountinhibit, mscratch.
// Latency: one cycle from request to registered response. No backpressure.
// Ports: req_valid_i/csr_addr_i/csr_op_i/csr_wdata_i request, instret_i and
// hpm_event_i count sources, rsp_valid_o/rsp_rdata_o/rsp_illegal_o response.
module csr_counter_unit
  import csr_counter_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_WIDTH    = 64,
  parameter int NUM_HPM      = 4,
  parameter int CSR_ADDR_W   = 12,
  parameter int CSR_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  input  logic [CSR_ADDR_W-1:0]   csr_addr_i,
  input  logic [CSR_OP_WIDTH-1:0] csr_op_i,
  input  logic [XLEN-1:0]         csr_wdata_i,
  input  logic                    instret_i,
  input  logic [NUM_HPM-1:0]      hpm_event_i,
  output logic                    rsp_valid_o,
  output logic [XLEN-1:0]         rsp_rdata_o,
  output logic                    rsp_illegal_o
);

  localparam int NUM_CNT = 2 + NUM_HPM;
  localparam logic [XLEN-1:0] INH_MASK = XLEN'(inh_mask(NUM_HPM));

  logic [11:0]          addr;
  logic [NUM_CNT-1:0]   sel_lo, sel_hi;
  logic                 sel_inh, sel_scr, hit;
  logic [11:0]          off;
  logic [XLEN-1:0]      old_val, new_val;
  csr_opk_e             opk;
  logic                 wr_attempt, illegal, do_wr;

  logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0]   cnt_evt;
  logic [XLEN-1:0]      mscratch_q, mcountinhibit_q;

  assign addr    = 12'(csr_addr_i);
  assign cnt_evt = {hpm_event_i, instret_i, 1'b1};

  // Address decode: one-hot selects across all mapped CSRs.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    off    = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      off = cnt_offset(i);
      if (addr == (ADDR_MCYCLE + off) || addr == (ADDR_CYCLE + off))
        sel_lo[i] = 1'b1;
      if (addr == (ADDR_MCYCLEH + off) || addr == (ADDR_CYCLEH + off))
        sel_hi[i] = 1'b1;
    end
    // time/timeh have no separate timer here; they mirror mcycle.
    if (addr == ADDR_TIME)  sel_lo[0] = 1'b1;
    if (addr == ADDR_TIMEH) sel_hi[0] = 1'b1;
    sel_inh = (addr == ADDR_MCOUNTINHIBIT);
    sel_scr = (addr == ADDR_MSCRATCH);
    hit     = (|sel_lo) | (|sel_hi) | sel_inh | sel_scr;
  end

  // Read mux; selects are one-hot so an OR tree suffices.
  always_comb begin
    old_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (sel_lo[i]) old_val = old_val | cnt_val[i][XLEN-1:0];
      if (sel_hi[i]) old_val = old_val | cnt_val[i][CNT_WIDTH-1:XLEN];
    end
    if (sel_inh) old_val = old_val | mcountinhibit_q;
    if (sel_scr) old_val = old_val | mscratch_q;
  end

  // Op ALU. Set/clear with a zero mask are pure reads, so they may target
  // read-only CSRs without faulting.
  always_comb begin
    opk        = OPK_NONE;
    new_val    = old_val;
    wr_attempt = 1'b0;
    case (csr_op_i)
      OP_RW, OP_RWI: opk = OPK_RW;
      OP_RS, OP_RSI: opk = OPK_RS;
      OP_RC, OP_RCI: opk = OPK_RC;
      default:       opk = OPK_NONE;
    endcase
    case (opk)
      OPK_RW: begin
        new_val    = csr_wdata_i;
        wr_attempt = 1'b1;
      end
      OPK_RS: begin
        new_val    = old_val | csr_wdata_i;
        wr_attempt = |csr_wdata_i;
      end
      OPK_RC: begin
        new_val    = old_val & ~csr_wdata_i;
        wr_attempt = |csr_wdata_i;
      end
      default: begin
        new_val    = old_val;
        wr_attempt = 1'b0;
      end
    endcase
    illegal = !hit || (opk == OPK_NONE) || (wr_attempt && `CSR_ADDR_IS_RO(addr));
    do_wr   = req_valid_i && !illegal && wr_attempt;
  end

  // Counter bank. Read-only aliases never reach wr_lo/wr_hi because any
  // write to them is flagged illegal above.
  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    localparam int IB = inh_bit(gi);
    logic inc_en;
    assign inc_en = cnt_evt[gi] & ~mcountinhibit_q[IB];

    csr_counter64 #(
      .XLEN      (XLEN),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_en (inc_en),
      .wr_lo  (do_wr & sel_lo[gi]),
      .wr_hi  (do_wr & sel_hi[gi]),
      .wdata  (new_val),
      .value  (cnt_val[gi])
    );
  end

  // Plain registers and the response stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      mscratch_q      <= '0;
      mcountinhibit_q <= '0;
      rsp_valid_o     <= 1'b0;
      rsp_rdata_o     <= '0;
      rsp_illegal_o   <= 1'b0;
    end else begin
      if (do_wr && sel_scr) mscratch_q      <= new_val;
      if (do_wr && sel_inh) mcountinhibit_q <= new_val & INH_MASK;
      rsp_valid_o   <= req_valid_i;
      rsp_illegal_o <= req_valid_i && illegal;
      rsp_rdata_o   <= (req_valid_i && !illegal) ? old_val : '0;
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Self-checking bench for csr_counter_unit: scoreboarded requests, a vector
// table for mscratch/decode cases, hand sequences for counter timing and reset.
// Edge numbering: E1 is the first posedge with rst low; a request at En
// returns the mcycle value n-1.
module tb_csr_counter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        instret;
  logic [3:0]  hpm_event;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  always #5 clk = ~clk;

  csr_counter_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .csr_addr_i    (csr_addr),
    .csr_op_i      (csr_op),
    .csr_wdata_i   (csr_wdata),
    .instret_i     (instret),
    .hpm_event_i   (hpm_event),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_illegal_o (rsp_illegal)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    int          tag;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[18];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s tag=%0d: got %h, required %h", nm, tag, act, req);
    end
  endtask

  // Drive a request for the coming posedge and record its expected response.
  task automatic drive(input logic [11:0] a, input logic [2:0] op, input logic [31:0] wd,
                       input logic [31:0] er, input logic ei, input int tag,
                       input logic ir = 1'b0, input logic [3:0] hpm = 4'b0);
    exp_t e;
    req_valid = 1'b1;
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = wd;
    instret   = ir;
    hpm_event = hpm;
    e.rdata = er;
    e.ill   = ei;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [11:0] a, input logic [2:0] op, input logic [31:0] wd,
                       input logic [31:0] er, input logic ei, input int tag,
                       input logic ir = 1'b0, input logic [3:0] hpm = 4'b0);
    @(negedge clk);
    drive(a, op, wd, er, ei, tag, ir, hpm);
  endtask

  task automatic idle(input int n, input logic ir = 1'b0, input logic [3:0] hpm = 4'b0);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      instret   = ir;
      hpm_event = hpm;
    end
  endtask

  // Response monitor: each posedge either retires the one expected response
  // or must show no response at all.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("idle_valid", -1, 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", e.tag, 32'(rsp_valid), 32'd1);
          chk("rsp_rdata", e.tag, rsp_rdata, e.rdata);
          chk("rsp_illegal", e.tag, 32'(rsp_illegal), 32'(e.ill));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    instret = 1'b0; hpm_event = '0;

    vecs[0]  = '{12'h340, 3'd1, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[1]  = '{12'h340, 3'd3, 32'h0000_00FF, 32'hA5A5_A5A5, 1'b0};
    vecs[2]  = '{12'h340, 3'd2, 32'h0000_0000, 32'hA5A5_A500, 1'b0};
    vecs[3]  = '{12'h340, 3'd6, 32'h0000_000F, 32'hA5A5_A500, 1'b0};
    vecs[4]  = '{12'h340, 3'd7, 32'h0000_0000, 32'hA5A5_A50F, 1'b0};
    vecs[5]  = '{12'h340, 3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{12'h340, 3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[7]  = '{12'h341, 3'd1, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[8]  = '{12'hC02, 3'd2, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[9]  = '{12'hC82, 3'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{12'hC02, 3'd2, 32'h0000_0000, 32'h0000_0002, 1'b0};
    vecs[11] = '{12'h340, 3'd1, 32'h0000_0000, 32'hA5A5_A50F, 1'b0};
    vecs[12] = '{12'h340, 3'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[13] = '{12'hB06, 3'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{12'hB07, 3'd2, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[15] = '{12'hB82, 3'd1, 32'h0000_0003, 32'h0000_0000, 1'b0};
    vecs[16] = '{12'hC82, 3'd2, 32'h0000_0000, 32'h0000_0003, 1'b0};
    vecs[17] = '{12'hC02, 3'd2, 32'h0000_0000, 32'h0000_0002, 1'b0};

    // Reset, with a would-be mscratch write in the reset cycle (discarded).
    @(negedge clk);
    req_valid = 1'b1; csr_addr = 12'h340; csr_op = 3'd1; csr_wdata = 32'h1234;
    @(negedge clk);   // N0: release reset; E1 follows
    req_valid = 1'b0;
    chk("reset_valid", 0, 32'(rsp_valid), 32'd0);
    chk("reset_rdata", 0, rsp_rdata, 32'd0);
    chk("reset_illegal", 0, 32'(rsp_illegal), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(9);                                             // E1..E10 idle

    issue(12'hC00, 3'd2, 32'h0, 32'd10, 1'b0, 100);      // E11
    issue(12'hB00, 3'd1, 32'hFFFF_FFFF, 32'd11, 1'b0, 101);
    issue(12'hB80, 3'd2, 32'h0, 32'd0, 1'b0, 102);       // carry lands this edge
    issue(12'hB80, 3'd2, 32'h0, 32'd1, 1'b0, 103);
    issue(12'hB00, 3'd2, 32'h0, 32'd1, 1'b0, 104);       // low half wrapped
    idle(2, 1'b1);                                       // E16,E17: minstret -> 2
    issue(12'h320, 3'd5, 32'd5, 32'd0, 1'b0, 105);       // E18: inhibit cy+ir
    idle(3, 1'b1);                                       // E19..E21 inhibited
    issue(12'hB02, 3'd2, 32'h0, 32'd2, 1'b0, 106);       // E22
    issue(12'h320, 3'd2, 32'h0, 32'd5, 1'b0, 107);
    issue(12'h320, 3'd2, 32'hFFFF_FFFF, 32'd5, 1'b0, 108);
    issue(12'h320, 3'd2, 32'h0, 32'h7D, 1'b0, 109);      // bit1/unimpl read 0
    issue(12'hB00, 3'd2, 32'h0, 32'd5, 1'b0, 110);       // frozen since E18
    issue(12'hC80, 3'd2, 32'h0, 32'd1, 1'b0, 111);
    issue(12'hC00, 3'd1, 32'h1234, 32'd0, 1'b1, 112);    // write to RO alias
    issue(12'hB00, 3'd2, 32'h0, 32'd5, 1'b0, 113);
    issue(12'hC01, 3'd2, 32'h0, 32'd5, 1'b0, 114);       // time mirrors mcycle
    issue(12'h340, 3'd4, 32'h0, 32'd0, 1'b1, 115);
    issue(12'h320, 3'd1, 32'h0, 32'h7D, 1'b0, 116);      // E32: uninhibit all
    issue(12'hB03, 3'd1, 32'd7, 32'd0, 1'b0, 117, 1'b0, 4'b0001); // write beats event
    issue(12'hB03, 3'd2, 32'h0, 32'd7, 1'b0, 118);
    idle(1, 1'b0, 4'b0011);                              // E35
    issue(12'hC03, 3'd2, 32'h0, 32'd8, 1'b0, 119);
    issue(12'hB04, 3'd2, 32'h0, 32'd1, 1'b0, 120);
    issue(12'hB00, 3'd2, 32'h0, 32'h0000_000A, 1'b0, 121); // counts E33..E37

    for (int i = 0; i < 18; i++)
      issue(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_ill, i);

    // Reset in the middle of a burst.
    issue(12'h340, 3'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 300);
    issue(12'h340, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 301);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; csr_addr = 12'h340; csr_op = 3'd1; csr_wdata = 32'h1;
    @(negedge clk);
    chk("midrst_valid", 310, 32'(rsp_valid), 32'd0);
    chk("midrst_rdata", 311, rsp_rdata, 32'd0);
    chk("midrst_illegal", 312, 32'(rsp_illegal), 32'd0);
    rst = 1'b0;
    drive(12'hB00, 3'd2, 32'h0, 32'd0, 1'b0, 302);       // first edge after reset
    issue(12'hB00, 3'd2, 32'h0, 32'd1, 1'b0, 303);
    issue(12'h340, 3'd2, 32'h0, 32'd0, 1'b0, 304);
    issue(12'h320, 3'd2, 32'h0, 32'd0, 1'b0, 305);
    idle(2);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
